// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: turns button press events into timer enable, a one-cycle counter clear and a lap-freeze display mux.
// Latency: a button rise changes state, enable, running, lap_active and clear one cycle later; the display mux is combinational.
// Backpressure: none; events not legal in the current state are dropped, never queued. Lap support is built only with `STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_stop_btn,
  input  logic                lap_btn,
  input  logic                clear_btn,
  input  logic [4*DIGITS-1:0] number,
  output logic                enable,
  output logic                clear,
  output logic [4*DIGITS-1:0] display,
  output logic                running,
  output logic                lap_active
);

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
`endif

  state_t state;
  state_t state_nxt;
  logic   ss_prev;
  logic   clr_prev;
  logic   ss_ev;
  logic   clr_ev;
  logic   clear_nxt;

  // History starts at 1 so that a button held through reset is not seen as a press.
  assign ss_ev  = start_stop_btn & ~ss_prev;
  assign clr_ev = clear_btn & ~clr_prev;

`ifdef STOPWATCH_LAP_EN
  logic                lap_prev;
  logic                lap_ev;
  logic                capture;
  logic [4*DIGITS-1:0] lap_reg;

  assign lap_ev = lap_btn & ~lap_prev;

  // Lap button history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lap_prev <= 1'b1;
    else     lap_prev <= lap_btn;
  end

  // Frozen lap value: taken verbatim on entry to LAP and held until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lap_reg <= '0;
    else if (capture) lap_reg <= number;
  end
`else
  logic unused_lap_btn;
  assign unused_lap_btn = lap_btn;
`endif

  // Start/stop and clear button history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_prev  <= 1'b1;
      clr_prev <= 1'b1;
    end else begin
      ss_prev  <= start_stop_btn;
      clr_prev <= clear_btn;
    end
  end

  // State register and registered clear pulse; reset cancels any pending pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      clear <= 1'b0;
    end else begin
      state <= state_nxt;
      clear <= clear_nxt;
    end
  end

  // Next state: clear > start_stop > lap, and only events legal in the current state act.
  always_comb begin
    state_nxt = state;
    clear_nxt = 1'b0;
`ifdef STOPWATCH_LAP_EN
    capture   = 1'b0;
`endif
    case (state)
      IDLE, PAUSE: begin
        if (clr_ev) begin
          state_nxt = IDLE;
          clear_nxt = 1'b1;
        end else if (ss_ev) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (ss_ev) begin
          state_nxt = PAUSE;
        end
`ifdef STOPWATCH_LAP_EN
        else if (lap_ev) begin
          state_nxt = LAP;
          capture   = 1'b1;
        end
`endif
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (ss_ev)       state_nxt = PAUSE;
        else if (lap_ev) state_nxt = RUN;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Moore output decode; the display mux is the only path from number to an output.
  always_comb begin
`ifdef STOPWATCH_LAP_EN
    running    = (state == RUN) || (state == LAP);
    lap_active = (state == LAP);
    display    = (state == LAP) ? lap_reg : number;
`else
    running    = (state == RUN);
    lap_active = 1'b0;
    display    = number;
`endif
    enable = running;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed then random button traffic against a run/lap reference model.
// Expected outputs are queued per cycle by the driver and popped by an independent monitor.
module tb_stopwatch_ctrl;
  localparam int W = 8;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         ss;
  logic         lap;
  logic         clr;
  logic [W-1:0] number;
  logic         enable;
  logic         clear;
  logic [W-1:0] display;
  logic         running;
  logic         lap_active;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DIGITS(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_stop_btn (ss),
    .lap_btn        (lap),
    .clear_btn      (clr),
    .number         (number),
    .enable         (enable),
    .clear          (clear),
    .display        (display),
    .running        (running),
    .lap_active     (lap_active)
  );

  typedef struct packed {
    logic         enable;
    logic         running;
    logic         lap_active;
    logic         clear;
    logic [W-1:0] display;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: is the count advancing, is the display frozen, and what was frozen.
  bit         m_run;
  bit         m_lap;
  logic [W-1:0] m_lap_val;
  bit         p_ss, p_lap, p_clr;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run     = 1'b0;
    m_lap     = 1'b0;
    m_lap_val = '0;
    p_ss      = 1'b1;
    p_lap     = 1'b1;
    p_clr     = 1'b1;
  endtask

  // Drive one cycle of button levels and number, queue what the outputs must be after the next edge.
  task automatic step(input string name, input bit s, input bit l, input bit c, input logic [W-1:0] n);
    bit   es, el, ec, pulse;
    exp_t e;
    ss = s; lap = l; clr = c; number = n;
    es = s && !p_ss;
    el = l && !p_lap;
    ec = c && !p_clr;
    p_ss = s; p_lap = l; p_clr = c;
    pulse = 1'b0;
    if (!m_run) begin
      if (ec)      pulse = 1'b1;
      else if (es) m_run = 1'b1;
    end else if (es) begin
      m_run = 1'b0;
      m_lap = 1'b0;
    end else if (el && LAP_EN) begin
      if (m_lap) m_lap = 1'b0;
      else begin
        m_lap     = 1'b1;
        m_lap_val = n;
      end
    end
    e.enable     = m_run;
    e.running    = m_run;
    e.lap_active = m_lap;
    e.clear      = pulse;
    e.display    = m_lap ? m_lap_val : n;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk); #2;
  endtask

  // Asynchronous reset: outputs must drop before any clock edge.
  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    chk_bit({name, "_enable"}, enable, 1'b0);
    chk_bit({name, "_running"}, running, 1'b0);
    chk_bit({name, "_clear"}, clear, 1'b0);
    chk_bit({name, "_lap_active"}, lap_active, 1'b0);
    chk_val({name, "_display"}, display, number);
`ifdef STOPWATCH_LAP_EN
    chk_val({name, "_lap_reg"}, dut.lap_reg, 8'h00);
`endif
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: one queued expectation per clock edge, sampled just after the edge.
  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk_bit({nm, "_enable"}, enable, e.enable);
        chk_bit({nm, "_running"}, running, e.running);
        chk_bit({nm, "_lap_active"}, lap_active, e.lap_active);
        chk_bit({nm, "_clear"}, clear, e.clear);
        chk_val({nm, "_display"}, display, e.display);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    v[7:4] = 4'($urandom_range(0, 9));
    v[3:0] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin : driver
    int wait_cycles;
    rst = 1'b1; ss = 1'b1; lap = 1'b0; clr = 1'b0; number = 8'h11;
    model_reset();
    @(posedge clk); #2;
    chk_bit("reset_enable", enable, 1'b0);
    chk_bit("reset_clear", clear, 1'b0);
    chk_bit("reset_lap_active", lap_active, 1'b0);
    chk_val("reset_display", display, 8'h11);
    rst = 1'b0;
    model_reset();

    // Start/stop held through reset must not start the count.
    step("held_ss",    1, 0, 0, 8'h11);
    step("release",    0, 0, 0, 8'h12);
    step("start",      1, 0, 0, 8'h13);
    step("rel",        0, 0, 0, 8'h14);
    step("stop",       1, 0, 0, 8'h15);
    step("rel",        0, 0, 0, 8'h15);
    step("resume",     1, 0, 0, 8'h16);
    step("rel",        0, 0, 0, 8'h36);
    // Lap freeze and release.
    step("lap_in",     0, 1, 0, 8'h37);
    step("lap_hold",   0, 1, 0, 8'h40);
    step("lap_adv",    0, 0, 0, 8'h42);
    step("lap_out",    0, 1, 0, 8'h42);
    step("rel",        0, 0, 0, 8'h43);
    // Clear legality.
    step("clr_in_run", 0, 0, 1, 8'h44);
    step("rel",        0, 0, 0, 8'h45);
    step("stop2",      1, 0, 0, 8'h46);
    step("rel",        0, 0, 0, 8'h46);
    step("clr_pause",  0, 0, 1, 8'h46);
    step("clr_done",   0, 0, 0, 8'h00);
    step("clr_idle",   0, 0, 1, 8'h00);
    step("rel",        0, 0, 0, 8'h00);
    // Simultaneous clear and start_stop in PAUSE: clear wins.
    step("start3",     1, 0, 0, 8'h01);
    step("rel",        0, 0, 0, 8'h02);
    step("stop3",      1, 0, 0, 8'h03);
    step("rel",        0, 0, 0, 8'h03);
    step("clr_ss",     1, 0, 1, 8'h03);
    step("rel",        0, 0, 0, 8'h00);
    // Simultaneous start_stop and lap in RUN: stop wins, lap value untouched.
    step("start4",     1, 0, 0, 8'h50);
    step("rel",        0, 0, 0, 8'h51);
    step("lap4",       0, 1, 0, 8'h55);
    step("rel",        0, 0, 0, 8'h56);
    step("unlap4",     0, 1, 0, 8'h57);
    step("rel",        0, 0, 0, 8'h60);
    step("ss_lap",     1, 1, 0, 8'h66);
    step("rel",        0, 0, 0, 8'h67);
`ifdef STOPWATCH_LAP_EN
    chk_val("lap_reg_kept", dut.lap_reg, m_lap_val);
`endif
    // Reset while in LAP.
    step("start5",     1, 0, 0, 8'h70);
    step("rel",        0, 0, 0, 8'h71);
    step("lap5",       0, 1, 0, 8'h77);
    step("rel",        0, 0, 0, 8'h78);
    do_reset("rst_in_lap");
    // Reset cancels a pending clear pulse.
    step("idle6",      0, 0, 0, 8'h00);
    step("clr6",       0, 0, 1, 8'h00);
    do_reset("rst_on_pulse");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand_rst");
      end else begin
        step("rand",
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0),
             rand_bcd());
      end
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk); #2;
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the stopwatch datapath. It turns debounced start/stop, lap and clear buttons into the timer `enable` and a one-cycle counter `clear`. It also selects whether the display shows the live BCD count or a frozen lap value. It sits between the button conditioning logic and the timer/bcd_counter pair, and feeds the seven-segment driver.

## Interface
- `DIGITS`, default 2: number of BCD digits, each 4 bits wide.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_stop_btn` in 1: debounced, synchronized level; rising edge is detected internally.
- `lap_btn` in 1: debounced, synchronized level; rising edge is detected internally.
- `clear_btn` in 1: debounced, synchronized level; rising edge is detected internally.
- `number` in 4*DIGITS: live BCD count from bcd_counter.
- `enable` out 1: timer enable.
- `clear` out 1: one-cycle clear pulse to bcd_counter.
- `display` out 4*DIGITS: value sent to the display driver.
- `running` out 1: high while the count is advancing.
- `lap_active` out 1: high while the display is frozen on a lap value.

## Operation
- Edge detect:
  - One previous-value register per button; all reset to 1, so a button held through reset does not count as a press.
  - A press event is `btn & ~prev`. It lasts exactly one cycle per physical press.
- States: IDLE, RUN, PAUSE, LAP.
- Transitions (only events listed for a state are legal; all others are dropped, not queued):
  - IDLE: start_stop → RUN. clear → IDLE and issue a clear pulse.
  - RUN: start_stop → PAUSE. lap → LAP and capture `number` into `lap_reg`.
  - PAUSE: start_stop → RUN. clear → IDLE and issue a clear pulse.
  - LAP: lap → RUN (release the display). start_stop → PAUSE (display returns to live).
- Priority for simultaneous events in one cycle: clear > start_stop > lap. Only the highest-priority legal event acts; the others are discarded.
- Clear in RUN or LAP is ignored; the count must be stopped first.
- Output decode (Moore, from the registered state):
  - `enable` = `running` = state ∈ {RUN, LAP}.
  - `lap_active` = (state == LAP).
  - `display` = `lap_reg` when in LAP, else `number` (combinational mux).
- `lap_reg` width is 4*DIGITS. It is stored verbatim with no arithmetic and holds its value until the next capture or reset.
- `clear` is a registered pulse: high for exactly one cycle. A clear event in IDLE still pulses, so the counter is re-zeroed.

## Timing
- Reset values: state IDLE, `enable` 0, `clear` 0, `running` 0, `lap_active` 0, `lap_reg` 0, previous-value registers 1. `display` follows `number`.
- Reset asserted mid-operation forces all of the above immediately (asynchronous). A pending clear pulse is cancelled.
- Event-to-output latency: an edge sampled at clock edge N updates state at N. `enable`, `running`, `lap_active` and `clear` change in the cycle that starts at N, which is one cycle after the button rises.
- `lap_reg` captures the value of `number` present at edge N.
- `display` switches to `lap_reg` in the same cycle that `lap_active` rises.
- Back-to-back presses on consecutive cycles are impossible for the same button, because a second press needs a low cycle. Presses on different buttons in consecutive cycles are each processed.
- Holding a button produces one event only.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - LAP state, `lap_reg` and the lap edge detector are present, as described above.
- `STOPWATCH_LAP_EN` undefined:
  - No LAP state and no `lap_reg`.
  - `lap_btn` is unused.
  - `lap_active` is tied to 0.
  - `display` is `number`.
  - RUN reacts only to start_stop.

## Test plan
- Reset, then check outputs. Release `rst` with `start_stop_btn` held high → state IDLE, `enable` stays 0 with no spurious start, `display` equals `number`.
- Start and stop. Press start_stop → `enable` 1 one cycle after the rise. Press again → `enable` 0 and `running` 0. Press again → `enable` 1 and the count resumes without reset.
- Lap. In RUN with `number` = 8'h37, press lap:
  - `lap_active` goes to 1 and `display` holds 8'h37 while `number` advances to 8'h42; `enable` stays 1.
  - Press lap again → `display` shows live 8'h42.
- Clear rules:
  - Press clear in RUN → no pulse, no state change.
  - In PAUSE, press clear → exactly one cycle of `clear`, then state IDLE with `enable` 0.
  - Press clear in IDLE → one more pulse.
- Simultaneous events. In PAUSE, raise clear and start_stop in the same cycle → clear wins: pulse issued, state IDLE, `enable` 0. In RUN, raise start_stop and lap together → PAUSE, and `lap_reg` is unchanged.
- Mid-operation reset and the macro-off build:
  - Assert `rst` during LAP → `lap_active`, `enable` and `lap_reg` go to 0 immediately.
  - With `STOPWATCH_LAP_EN` undefined, lap presses in RUN → no effect on `display` or `lap_active`.
